// File: rtl/uart_tx_bridge.sv
// Frame-to-byte serializer feeding a low-level UART transmitter.
// Accepts {message, header} in one handshake and emits it LSB byte first, header first.
module uart_tx_bridge #(
  parameter int MESSAGE_SIZE = 512,
  parameter int HEADER_SIZE  = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [HEADER_SIZE-1:0]  header_in,
  input  logic [MESSAGE_SIZE-1:0] message_in,
  input  logic                    ctrl_valid_in,
  output logic                    bdge_ready_out,
  output logic [7:0]              ll_byte_out,
  output logic                    ll_valid_out,
  input  logic                    ll_ready_in,
  output logic                    frame_done_out
);

  localparam int FRAME_SIZE  = HEADER_SIZE + MESSAGE_SIZE;
  localparam int TOTAL_BYTES = FRAME_SIZE / 8;
  localparam int CNT_W       = $clog2(TOTAL_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_reg,  state_next;
  logic [FRAME_SIZE-1:0]   buffer_reg, buffer_next;
  logic [CNT_W-1:0]        count_reg,  count_next;
  logic                    valid_reg,  valid_next;
  logic                    done_reg,   done_next;
  logic                    transfer;

  assign transfer = valid_reg & ll_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg  <= IDLE;
      buffer_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      buffer_reg <= buffer_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    buffer_next = buffer_reg;
    count_next  = count_reg;
    valid_next  = valid_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ctrl_valid_in) begin
          buffer_next = {message_in, header_in};
          count_next  = '0;
          valid_next  = 1'b1;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (transfer) begin
          if (count_reg == LAST_IDX) begin
            // Buffer is left unshifted; ll_byte_out is ignored once valid drops.
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            buffer_next = buffer_reg >> 8;
            count_next  = count_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // The current byte is always the low byte of the shifting buffer.
  assign ll_byte_out    = buffer_reg[7:0];
  assign ll_valid_out   = valid_reg;
  assign bdge_ready_out = (state_reg == IDLE);
  assign frame_done_out = done_reg;

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed bench for uart_tx_bridge: per-scenario tasks with inline checks.
// Transfers are recorded by a negedge monitor and rebuilt into frames for comparison.
module tb_uart_tx_bridge;
  localparam int HS = 32;
  localparam int MS = 512;
  localparam int FW = HS + MS;
  localparam int TB = FW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HS-1:0] header;
  logic [MS-1:0] message;
  logic          ctrl_valid;
  logic          bdge_ready;
  logic [7:0]    ll_byte;
  logic          ll_valid;
  logic          ll_ready;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] q_byte[$];
  int         q_cyc[$];

  always #5 clk = ~clk;

  uart_tx_bridge #(.MESSAGE_SIZE(MS), .HEADER_SIZE(HS)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .header_in(header), .message_in(message),
    .ctrl_valid_in(ctrl_valid), .bdge_ready_out(bdge_ready), .ll_byte_out(ll_byte),
    .ll_valid_out(ll_valid), .ll_ready_in(ll_ready), .frame_done_out(frame_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && ll_valid && ll_ready) begin
      q_byte.push_back(ll_byte);
      q_cyc.push_back(cyc);
    end
    if (rst_n && frame_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [7:0] exp_byte(input logic [HS-1:0] h, input logic [MS-1:0] m, input int i);
    logic [FW-1:0] f;
    f = {m, h};
    return f[i*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until frame_done is seen; ready pattern: 0=always 1, 1=alternate.
  task automatic run_to_done(input int pattern, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      ll_ready = (pattern == 0) ? 1'b1 : k[0];
      step();
      if (frame_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    q_byte.delete();
    q_cyc.delete();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ctrl_valid = 1'b0; ll_ready = 1'b0; header = '0; message = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (bdge_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bdge_ready); end
    n_cmp++; if (ll_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", ll_valid); end
    n_cmp++; if (ll_byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte got=%h want=00", ll_byte); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
  endtask

  task automatic test_basic();
    logic [HS-1:0] h;
    logic [MS-1:0] m;
    int bad_bytes;
    int d0;
    h = 32'hFAFA_FAFA;
    m = {8{64'h0123456789abcdef}};
    bad_bytes = 0;
    d0 = done_cnt;
    header = h; message = m; ctrl_valid = 1'b1; ll_ready = 1'b0;
    step();
    ctrl_valid = 1'b0; header = '1; message = '1;
    n_cmp++; if (bdge_ready !== 1'b0) begin n_bad++; $display("FAIL basic_busy got=%b want=0", bdge_ready); end
    n_cmp++; if (ll_valid !== 1'b1 || ll_byte !== 8'hFA) begin n_bad++; $display("FAIL basic_first got=%b/%h want=1/fa", ll_valid, ll_byte); end
    for (int i = 0; i < TB; i++) begin
      repeat (8) step();
      if (ll_valid !== 1'b1 || ll_byte !== exp_byte(h, m, i)) begin
        bad_bytes++;
        $display("FAIL basic_byte%0d got=%b/%h want=1/%h", i, ll_valid, ll_byte, exp_byte(h, m, i));
      end
      ll_ready = 1'b1;
      step();
      ll_ready = 1'b0;
    end
    n_cmp++; if (bad_bytes != 0) begin n_bad++; $display("FAIL basic_bytes got=%0d bad want=0", bad_bytes); end
    n_cmp++; if (frame_done !== 1'b1 || ll_valid !== 1'b0 || bdge_ready !== 1'b1)
      begin n_bad++; $display("FAIL basic_end got=done%b/valid%b/ready%b want=1/0/1", frame_done, ll_valid, bdge_ready); end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL basic_pulse got=%b want=0", frame_done); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_loopback();
    logic [HS-1:0] h;
    logic [MS-1:0] m;
    logic [FW-1:0] rx;
    bit to;
    h = 32'hBCBC_BCBC;
    m = {8{64'hfedcba9876543210}};
    rx = '0;
    clear_log();
    header = h; message = m; ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    run_to_done(1, to);
    ll_ready = 1'b0;
    step();
    n_cmp++; if (to) begin n_bad++; $display("FAIL loop_timeout got=timeout want=done"); end
    n_cmp++; if (q_byte.size() != TB) begin n_bad++; $display("FAIL loop_count got=%0d want=%0d", q_byte.size(), TB); end
    for (int i = 0; i < TB && i < q_byte.size(); i++) rx[i*8 +: 8] = q_byte[i];
    n_cmp++; if (rx[HS-1:0] !== h) begin n_bad++; $display("FAIL loop_header got=%h want=%h", rx[HS-1:0], h); end
    n_cmp++; if (rx[FW-1:HS] !== m) begin n_bad++; $display("FAIL loop_message got=%h want=%h", rx[FW-1:HS], m); end
  endtask

  task automatic test_stall();
    logic [HS-1:0] h;
    logic [MS-1:0] m;
    logic [7:0] held;
    int n, moved, bad;
    bit to;
    h = 32'h0302_0100;
    m = {16{32'h1357_9bdf}} ^ {64{8'h5a}};
    n = 0; moved = 0; bad = 0;
    clear_log();
    header = h; message = m; ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0; ll_ready = 1'b1;
    while (n < 10) begin
      if (ll_valid) n++;
      step();
    end
    ll_ready = 1'b0;
    held = ll_byte;
    for (int k = 0; k < 50; k++) begin
      step();
      if (ll_byte !== held || ll_valid !== 1'b1) moved++;
    end
    n_cmp++; if (moved != 0) begin n_bad++; $display("FAIL stall_hold got=%0d changes want=0", moved); end
    n_cmp++; if (held !== exp_byte(h, m, 10)) begin n_bad++; $display("FAIL stall_byte10 got=%h want=%h", held, exp_byte(h, m, 10)); end
    run_to_done(0, to);
    ll_ready = 1'b0;
    step();
    n_cmp++; if (to || q_byte.size() != TB) begin n_bad++; $display("FAIL stall_count got=%0d want=%0d", q_byte.size(), TB); end
    for (int i = 0; i < q_byte.size() && i < TB; i++) if (q_byte[i] !== exp_byte(h, m, i)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stall_order got=%0d bad want=0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [HS-1:0] ha, hb;
    logic [MS-1:0] ma, mb;
    int bad, gaps;
    bit to;
    ha = 32'hA1A2_A3A4; ma = {8{64'h1122334455667788}};
    hb = 32'hB1B2_B3B4; mb = {8{64'h99aabbccddeeff00}};
    bad = 0; gaps = 0;
    clear_log();
    header = ha; message = ma; ctrl_valid = 1'b1; ll_ready = 1'b1;
    step();
    header = hb; message = mb;
    run_to_done(0, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL b2b_timeout1 got=timeout want=done"); end
    n_cmp++; if (bdge_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_done got=%b want=1", bdge_ready); end
    step();
    ctrl_valid = 1'b0; header = '0; message = '0;
    run_to_done(0, to);
    ll_ready = 1'b0;
    step();
    n_cmp++; if (to || q_byte.size() != 2*TB) begin n_bad++; $display("FAIL b2b_count got=%0d want=%0d", q_byte.size(), 2*TB); end
    if (q_byte.size() == 2*TB) begin
      for (int i = 0; i < TB; i++) begin
        if (q_byte[i] !== exp_byte(ha, ma, i)) bad++;
        if (q_byte[TB+i] !== exp_byte(hb, mb, i)) bad++;
        if (i > 0 && q_cyc[i] != q_cyc[i-1] + 1) gaps++;
        if (i > 0 && q_cyc[TB+i] != q_cyc[TB+i-1] + 1) gaps++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_bytes got=%0d bad want=0", bad); end
      n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL b2b_full_rate got=%0d gaps want=0", gaps); end
      n_cmp++; if (q_cyc[TB] - q_cyc[TB-1] != 2) begin n_bad++; $display("FAIL b2b_gap got=%0d want=2", q_cyc[TB] - q_cyc[TB-1]); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [HS-1:0] h;
    logic [MS-1:0] m;
    int busy_bad, bad;
    bit to;
    h = 32'hC0DE_CAFE; m = {16{32'h0F1E_2D3C}};
    busy_bad = 0; bad = 0; to = 1'b1;
    clear_log();
    header = h; message = m; ctrl_valid = 1'b1; ll_ready = 1'b0;
    step();
    header = ~h; message = ~m;
    for (int k = 0; k < 3000; k++) begin
      ll_ready = k[0];
      header = header + 1'b1;
      if (bdge_ready !== 1'b0) busy_bad++;
      step();
      if (frame_done) begin to = 1'b0; break; end
    end
    ctrl_valid = 1'b0; ll_ready = 1'b0;
    n_cmp++; if (to || busy_bad != 0) begin n_bad++; $display("FAIL busy_ready got=%0d high want=0", busy_bad); end
    n_cmp++; if (bdge_ready !== 1'b1) begin n_bad++; $display("FAIL busy_end_ready got=%b want=1", bdge_ready); end
    step();
    for (int i = 0; i < q_byte.size() && i < TB; i++) if (q_byte[i] !== exp_byte(h, m, i)) bad++;
    n_cmp++; if (q_byte.size() != TB || bad != 0) begin n_bad++; $display("FAIL busy_bytes got=%0d/%0d bad want=%0d/0", q_byte.size(), bad, TB); end
  endtask

  task automatic test_reset_mid();
    logic [HS-1:0] h, hd;
    logic [MS-1:0] m, md;
    int n, d0, bad;
    bit to;
    h = 32'h7777_6666; m = {8{64'h0102030405060708}};
    hd = 32'h4433_2211; md = {8{64'hdeadbeef00c0ffee}};
    n = 0; bad = 0;
    clear_log();
    d0 = done_cnt;
    header = h; message = m; ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0; ll_ready = 1'b1;
    while (n < 30) begin
      if (ll_valid) n++;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ll_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%b want=0", ll_valid); end
    n_cmp++; if (ll_byte !== 8'h00) begin n_bad++; $display("FAIL rstmid_byte got=%h want=00", ll_byte); end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (bdge_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b want=1", bdge_ready); end
    n_cmp++; if (done_cnt != d0 || q_byte.size() != 30) begin n_bad++; $display("FAIL rstmid_partial got=%0d done/%0d bytes want=0/30", done_cnt - d0, q_byte.size()); end
    clear_log();
    header = hd; message = md; ctrl_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    n_cmp++; if (ll_byte !== hd[7:0]) begin n_bad++; $display("FAIL rstmid_first got=%h want=%h", ll_byte, hd[7:0]); end
    run_to_done(0, to);
    ll_ready = 1'b0;
    step();
    for (int i = 0; i < q_byte.size() && i < TB; i++) if (q_byte[i] !== exp_byte(hd, md, i)) bad++;
    n_cmp++; if (to || q_byte.size() != TB || bad != 0) begin n_bad++; $display("FAIL rstmid_next got=%0d/%0d bad want=%0d/0", q_byte.size(), bad, TB); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_stall();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
